// File: rtl/dso_pkg.sv
// Shared DSO definitions: trigger FSM states, trig_cfg field layout and
// threshold helpers used by the trigger unit and the capture controller.
package dso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ARM_WT = 2'd2,
        TRIG   = 2'd3
    } trig_state_t;

    localparam int CFG_POL_BIT  = 4;
    localparam int CFG_MODE_HI  = 3;
    localparam int CFG_MODE_LO  = 2;
    localparam int CFG_SRC_HI   = 1;
    localparam int CFG_SRC_LO   = 0;

    localparam logic [1:0] MODE_NORMAL   = 2'b01;
    localparam logic [1:0] MODE_AUTOROLL = 2'b10;

    localparam logic [1:0] SRC_CH1 = 2'b00;
    localparam logic [1:0] SRC_CH2 = 2'b01;
    localparam logic [1:0] SRC_CH3 = 2'b10;
    localparam logic [1:0] SRC_EXT = 2'b11;

    // Lower hysteresis bound, clamped at zero.
    function automatic logic [7:0] thr_lo(input logic [7:0] lvl, input int hyst);
        logic [8:0] w_lvl;
        logic [8:0] w_hyst;
        w_lvl  = {1'b0, lvl};
        w_hyst = 9'(hyst);
        if (w_lvl < w_hyst) return 8'd0;
        return 8'(w_lvl - w_hyst);
    endfunction

    // Upper hysteresis bound, clamped at full scale.
    function automatic logic [7:0] thr_hi(input logic [7:0] lvl, input int hyst);
        logic [8:0] w_sum;
        w_sum = {1'b0, lvl} + 9'(hyst);
        if (w_sum > 9'd255) return 8'hFF;
        return 8'(w_sum);
    endfunction

endpackage

// File: rtl/trig_sync.sv
// Synchronizer for the asynchronous external trigger pin followed by a
// registered polarity-selected edge detector. SYNC_STG must be at least 2.
module trig_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    input  logic i_polarity,
    output logic o_sync_lvl,
    output logic o_edge
);

    logic [SYNC_STG-1:0] r_chain;
    logic                r_prev;
    logic                r_edge;
    logic                w_sync;

    assign w_sync = r_chain[SYNC_STG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STG-2:0], i_async};
            r_prev  <= w_sync;
            // polarity 1 looks for 0->1, polarity 0 for 1->0
            r_edge  <= i_polarity ? (w_sync & ~r_prev) : (~w_sync & r_prev);
        end
    end

    assign o_sync_lvl = w_sync;
    assign o_edge     = r_edge;

endmodule

// File: rtl/trigger_unit.sv
// Trigger detector: hysteresis-qualified level crossing on a channel, or a
// synchronized external edge, driving the sticky triggered flag for capture.
module trigger_unit
    import dso_pkg::*;
#(
    parameter int HYST     = 4,
    parameter int SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] trig_cfg,
    input  logic       trig_en,
    input  logic       armed,
    input  logic       capture_done,
    input  logic       smpl_vld,
    input  logic [7:0] ch1_smpl,
    input  logic [7:0] ch2_smpl,
    input  logic [7:0] ch3_smpl,
    input  logic [7:0] trig_lvl,
    input  logic       ext_trig,
    output logic       triggered,
    output logic       trig_pulse,
    output logic [1:0] dbg_state
);

    trig_state_t r_state;
    trig_state_t w_state_nxt;
    logic        r_triggered;
    logic        r_pulse;

    logic        w_pol;
    logic [1:0]  w_mode;
    logic [1:0]  w_src;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    logic [7:0]  w_smpl;
    logic        w_ch_pre;
    logic        w_ch_fire;
    logic        w_ext_lvl;
    logic        w_ext_edge;
    logic        w_pre;
    logic        w_fire;

    assign w_pol  = trig_cfg[CFG_POL_BIT];
    assign w_mode = trig_cfg[CFG_MODE_HI:CFG_MODE_LO];
    assign w_src  = trig_cfg[CFG_SRC_HI:CFG_SRC_LO];
    assign w_lo   = thr_lo(trig_lvl, HYST);
    assign w_hi   = thr_hi(trig_lvl, HYST);

    always_comb begin
        w_smpl = ch1_smpl;
        case (w_src)
            SRC_CH2: w_smpl = ch2_smpl;
            SRC_CH3: w_smpl = ch3_smpl;
            default: w_smpl = ch1_smpl;
        endcase
    end

    // lo <= lvl <= hi, so a single sample can never be both pre-side and fire.
    assign w_ch_pre  = smpl_vld & (w_pol ? (w_smpl < w_lo) : (w_smpl > w_hi));
    assign w_ch_fire = smpl_vld & (w_pol ? (w_smpl >= trig_lvl) : (w_smpl <= trig_lvl));

    trig_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_trig_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_async    (ext_trig),
        .i_polarity (w_pol),
        .o_sync_lvl (w_ext_lvl),
        .o_edge     (w_ext_edge)
    );

    assign w_pre  = (w_src == SRC_EXT) ? (w_pol ? ~w_ext_lvl : w_ext_lvl) : w_ch_pre;
    assign w_fire = (w_src == SRC_EXT) ? w_ext_edge : w_ch_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (trig_en && !capture_done) w_state_nxt = PRIME;
            end
            PRIME: begin
                if (w_mode == MODE_AUTOROLL) begin
                    if (armed) w_state_nxt = TRIG;
                end else if (w_mode == MODE_NORMAL) begin
                    if (w_pre) w_state_nxt = ARM_WT;
                end
            end
            ARM_WT: begin
                // a crossing before capture is armed forces re-qualification
                if (w_fire) w_state_nxt = armed ? TRIG : PRIME;
            end
            TRIG: begin
                w_state_nxt = TRIG;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!trig_en || capture_done) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_triggered <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_triggered <= (w_state_nxt == TRIG);
            r_pulse     <= (w_state_nxt == TRIG) && (r_state != TRIG);
        end
    end

    assign triggered  = r_triggered;
    assign trig_pulse = r_pulse;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit with a cycle-level behavioural model and
// hand-computed checkpoints for each trigger scenario.
module tb_trigger_unit;

    localparam int HYST     = 4;
    localparam int SYNC_STG = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] trig_cfg;
    logic       trig_en;
    logic       armed;
    logic       capture_done;
    logic       smpl_vld;
    logic [7:0] ch1_smpl;
    logic [7:0] ch2_smpl;
    logic [7:0] ch3_smpl;
    logic [7:0] trig_lvl;
    logic       ext_trig;
    logic       triggered;
    logic       trig_pulse;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trigger_unit #(
        .HYST     (HYST),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig_cfg     (trig_cfg),
        .trig_en      (trig_en),
        .armed        (armed),
        .capture_done (capture_done),
        .smpl_vld     (smpl_vld),
        .ch1_smpl     (ch1_smpl),
        .ch2_smpl     (ch2_smpl),
        .ch3_smpl     (ch3_smpl),
        .trig_lvl     (trig_lvl),
        .ext_trig     (ext_trig),
        .triggered    (triggered),
        .trig_pulse   (trig_pulse),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_active: trigger enabled and hunting; m_qual: pre-side seen; m_trig: fired.
    logic       m_active, m_qual, m_trig;
    logic       ext_h[$];
    logic [1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        logic prev_trig, pre, fire, pol;
        int   lvl, lo, hi, s, src, mode;
        if (!rst_n) begin
            m_active = 1'b0;
            m_qual   = 1'b0;
            m_trig   = 1'b0;
            ext_h.delete();
            repeat (4) ext_h.push_back(1'b0);
            exp_q.delete();
        end else begin
            prev_trig = m_trig;
            pol  = trig_cfg[4];
            mode = int'(trig_cfg[3:2]);
            src  = int'(trig_cfg[1:0]);
            lvl  = int'(trig_lvl);
            lo   = (lvl - HYST < 0) ? 0 : lvl - HYST;
            hi   = (lvl + HYST > 255) ? 255 : lvl + HYST;
            s    = (src == 0) ? int'(ch1_smpl) : (src == 1) ? int'(ch2_smpl) : int'(ch3_smpl);
            if (src == 3) begin
                // ext_h[k] = pin value seen k+1 clock edges ago
                pre  = pol ? (ext_h[SYNC_STG-1] == 1'b0) : (ext_h[SYNC_STG-1] == 1'b1);
                fire = pol ? (ext_h[SYNC_STG] && !ext_h[SYNC_STG+1])
                           : (!ext_h[SYNC_STG] && ext_h[SYNC_STG+1]);
            end else begin
                pre  = smpl_vld && (pol ? (s < lo) : (s > hi));
                fire = smpl_vld && (pol ? (s >= lvl) : (s <= lvl));
            end
            if (!trig_en || capture_done) begin
                m_active = 1'b0;
                m_qual   = 1'b0;
                m_trig   = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (!m_trig) begin
                if (mode == 2) begin
                    if (armed) m_trig = 1'b1;
                end else if (mode == 1) begin
                    if (!m_qual) begin
                        if (pre) m_qual = 1'b1;
                    end else if (fire) begin
                        if (armed) m_trig = 1'b1;
                        else m_qual = 1'b0;
                    end
                end
            end
            exp_q.push_back({m_trig && !prev_trig, m_trig});
            ext_h.push_front(ext_trig);
            void'(ext_h.pop_back());
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            check("rst_triggered", {7'd0, triggered}, 8'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_triggered", {7'd0, triggered}, {7'd0, e[0]});
            check("model_pulse", {7'd0, trig_pulse}, {7'd0, e[1]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one valid sample on the selected channel; others carry the complement.
    task automatic smp(input logic [7:0] v);
        ch1_smpl = (trig_cfg[1:0] == 2'b00) ? v : ~v;
        ch2_smpl = (trig_cfg[1:0] == 2'b01) ? v : ~v;
        ch3_smpl = (trig_cfg[1:0] == 2'b10) ? v : ~v;
        smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
    endtask

    task automatic start(input logic [7:0] cfg, input logic [7:0] lvl, input logic arm);
        trig_cfg = cfg;
        trig_lvl = lvl;
        armed    = arm;
        trig_en  = 1'b1;
        tick(2);
    endtask

    task automatic stop();
        trig_en      = 1'b0;
        capture_done = 1'b0;
        armed        = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        trig_cfg = 8'h00; trig_en = 1'b0; armed = 1'b0; capture_done = 1'b0;
        smpl_vld = 1'b0; ch1_smpl = 8'h00; ch2_smpl = 8'h00; ch3_smpl = 8'h00;
        trig_lvl = 8'h00; ext_trig = 1'b0;
        tick(2);
        check("reset_triggered", {7'd0, triggered}, 8'd0);
        check("reset_pulse", {7'd0, trig_pulse}, 8'd0);
        check("reset_state", {6'd0, dbg_state}, 8'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: CH1 rising, lvl 0x80 (lo 0x7C)
        start(8'h14, 8'h80, 1'b1);
        smp(8'h70);
        smp(8'h7C);
        check("t1_before_fire", {7'd0, triggered}, 8'd0);
        smp(8'h80);
        check("t1_triggered", {7'd0, triggered}, 8'd1);
        check("t1_pulse", {7'd0, trig_pulse}, 8'd1);
        tick(1);
        check("t1_pulse_single", {7'd0, trig_pulse}, 8'd0);
        check("t1_sticky", {7'd0, triggered}, 8'd1);
        capture_done = 1'b1;
        tick(1);
        check("t1_done_clear", {7'd0, triggered}, 8'd0);
        stop();

        // 2: CH2 falling, lvl 0x40 (hi 0x44); unarmed crossing is ignored
        start(8'h05, 8'h40, 1'b0);
        smp(8'h50);
        smp(8'h40);
        check("t2_unarmed_ignored", {7'd0, triggered}, 8'd0);
        armed = 1'b1;
        smp(8'h50);
        check("t2_rearmed_wait", {7'd0, triggered}, 8'd0);
        smp(8'h3F);
        check("t2_triggered", {7'd0, triggered}, 8'd1);
        check("t2_pulse", {7'd0, trig_pulse}, 8'd1);
        stop();

        // 3: noise around the level never clears hysteresis
        start(8'h14, 8'h80, 1'b1);
        smp(8'h7E); smp(8'h81); smp(8'h7E); smp(8'h81);
        check("t3_noise_rejected", {7'd0, triggered}, 8'd0);
        smp(8'h70);
        smp(8'h85);
        check("t3_triggered", {7'd0, triggered}, 8'd1);
        stop();

        // 4: autoroll fires on armed with no samples
        start(8'h18, 8'h80, 1'b0);
        tick(46);
        check("t4_wait_armed", {7'd0, triggered}, 8'd0);
        armed = 1'b1;
        tick(1);
        check("t4_autoroll", {7'd0, triggered}, 8'd1);
        check("t4_pulse", {7'd0, trig_pulse}, 8'd1);
        stop();

        // 5: EXT rising, 3-clock asynchronous pulse
        start(8'h17, 8'h80, 1'b1);
        tick(4);
        #2 ext_trig = 1'b1;
        repeat (SYNC_STG + 1) @(posedge clk);
        #1 check("t5_not_yet", {7'd0, triggered}, 8'd0);
        #6 ext_trig = 1'b0;
        @(posedge clk);
        #1 check("t5_ext_triggered", {7'd0, triggered}, 8'd1);
        check("t5_ext_pulse", {7'd0, trig_pulse}, 8'd1);
        @(negedge clk);
        capture_done = 1'b1;
        @(posedge clk);
        #1 check("t5_done_clear", {7'd0, triggered}, 8'd0);
        @(negedge clk);
        stop();

        // 6: reset while triggered, then saturated thresholds
        start(8'h14, 8'h80, 1'b1);
        smp(8'h70);
        smp(8'h80);
        check("t6_in_trig", {7'd0, triggered}, 8'd1);
        #3 rst_n = 1'b0;
        #1 check("t6_rst_triggered", {7'd0, triggered}, 8'd0);
        check("t6_rst_pulse", {7'd0, trig_pulse}, 8'd0);
        check("t6_rst_state", {6'd0, dbg_state}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stop();
        start(8'h14, 8'h02, 1'b1);
        smp(8'h00); smp(8'h01); smp(8'h05); smp(8'h02);
        check("t6_lo_saturated", {7'd0, triggered}, 8'd0);
        stop();
        start(8'h04, 8'hFE, 1'b1);
        smp(8'hFF); smp(8'hF0); smp(8'hFF); smp(8'h00);
        check("t6_hi_saturated", {7'd0, triggered}, 8'd0);
        stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
